// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with full sideband and optional store-and-forward.
// First-word fall-through read port, registered s_tready.
module axis_packet_fifo #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int DEST_W      = 4,
  parameter int USER_W      = 4,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  parameter int KEEP_STRB_W = DATA_W / 8,
  parameter int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_W-1:0]      s_tdata,
  input  logic [KEEP_STRB_W-1:0] s_tstrb,
  input  logic [KEEP_STRB_W-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [ID_W-1:0]        s_tid,
  input  logic [DEST_W-1:0]      s_tdest,
  input  logic [USER_W-1:0]      s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_W-1:0]      m_tdata,
  output logic [KEEP_STRB_W-1:0] m_tstrb,
  output logic [KEEP_STRB_W-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [ID_W-1:0]        m_tid,
  output logic [DEST_W-1:0]      m_tdest,
  output logic [USER_W-1:0]      m_tuser,
  output logic [LVL_W-1:0]       level,
  output logic [LVL_W-1:0]       pkt_count,
  output logic                   pkt_oversize
);

  localparam int AW = LVL_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [KEEP_STRB_W-1:0] strb;
    logic [KEEP_STRB_W-1:0] keep;
    logic                   last;
    logic [ID_W-1:0]        id;
    logic [DEST_W-1:0]      dest;
    logic [USER_W-1:0]      user;
  } ent_t;

  ent_t             mem [DEPTH];
  ent_t             wr_ent;
  ent_t             rd_ent;
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic [LVL_W-1:0] pkt_nxt;
  logic             wr_en;
  logic             rd_en;
  logic             full_q;

  assign wr_en = s_tvalid && s_tready;
  assign rd_en = m_tvalid && m_tready;

  // Pointer MSB is the wrap bit, so the difference is the fill level.
  assign level = wr_ptr - rd_ptr;
  assign full_q = (level == LVL_W'(DEPTH));

  assign level_nxt = level + LVL_W'(wr_en) - LVL_W'(rd_en);
  assign pkt_nxt = pkt_count
                 + LVL_W'(wr_en && s_tlast)
                 - LVL_W'(rd_en && m_tlast);

  // Store-and-forward only releases data once a whole packet is held.
  always_comb begin
    m_tvalid = (level != '0);
    if (PACKET_MODE != 0)
      m_tvalid = (level != '0) && (pkt_count != '0);
  end

  assign wr_ent = '{
    data: s_tdata,
    strb: s_tstrb,
    keep: s_tkeep,
    last: s_tlast,
    id:   s_tid,
    dest: s_tdest,
    user: s_tuser
  };

  always_ff @(posedge ACLK) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= wr_ent;
  end

  assign rd_ent  = mem[rd_ptr[AW-1:0]];
  assign m_tdata = rd_ent.data;
  assign m_tstrb = rd_ent.strb;
  assign m_tkeep = rd_ent.keep;
  assign m_tlast = rd_ent.last;
  assign m_tid   = rd_ent.id;
  assign m_tdest = rd_ent.dest;
  assign m_tuser = rd_ent.user;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      s_tready  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      pkt_count <= pkt_nxt;
      s_tready  <= (level_nxt != LVL_W'(DEPTH));
    end
  end

  // Full with no complete packet can never drain in store-and-forward.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      pkt_oversize <= 1'b0;
    else if (PACKET_MODE != 0 && full_q && pkt_count == '0)
      pkt_oversize <= 1'b1;
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Scoreboard bench for axis_packet_fifo: one cut-through and one
// store-and-forward instance sharing the upstream payload bus.
module tb_axis_packet_fifo;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int LW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
    logic [KW-1:0] keep;
    logic          last;
    logic [3:0]    id;
    logic [3:0]    dest;
    logic [3:0]    user;
  } beat_t;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tstrb, s_tkeep;
  logic          s_tlast;
  logic [3:0]    s_tid, s_tdest, s_tuser;
  logic          sv0, sv1, mr0, mr1;

  logic          sr0, mv0, ml0, ov0;
  logic [DW-1:0] md0;
  logic [KW-1:0] ms0, mk0;
  logic [3:0]    mi0, mdst0, mu0;
  logic [LW-1:0] lvl0, pk0;

  logic          sr1, mv1, ml1, ov1;
  logic [DW-1:0] md1;
  logic [KW-1:0] ms1, mk1;
  logic [3:0]    mi1, mdst1, mu1;
  logic [LW-1:0] lvl1, pk1;

  axis_packet_fifo #(.PACKET_MODE(0)) u0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(sv0), .s_tready(sr0),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
    .s_tuser(s_tuser),
    .m_tvalid(mv0), .m_tready(mr0),
    .m_tdata(md0), .m_tstrb(ms0), .m_tkeep(mk0), .m_tlast(ml0),
    .m_tid(mi0), .m_tdest(mdst0), .m_tuser(mu0),
    .level(lvl0), .pkt_count(pk0), .pkt_oversize(ov0)
  );

  axis_packet_fifo #(.PACKET_MODE(1)) u1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(sv1), .s_tready(sr1),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
    .s_tuser(s_tuser),
    .m_tvalid(mv1), .m_tready(mr1),
    .m_tdata(md1), .m_tstrb(ms1), .m_tkeep(mk1), .m_tlast(ml1),
    .m_tid(mi1), .m_tdest(mdst1), .m_tuser(mu1),
    .level(lvl1), .pkt_count(pk1), .pkt_oversize(ov1)
  );

  int n_cmp = 0;
  int n_err = 0;
  beat_t q0[$];
  beat_t q1[$];
  int exp_lvl0 = 0;
  int exp_pk0 = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(logic [31:0] d, logic [3:0] st,
                               logic [3:0] kp, logic l, logic [3:0] i,
                               logic [3:0] de, logic [3:0] us);
    beat_t b;
    b = '{data: d, strb: st, keep: kp, last: l, id: i, dest: de, user: us};
    return b;
  endfunction

  // Instance 0 monitor: payload scoreboard plus level/pkt_count model
  always @(negedge ACLK) begin
    beat_t got;
    if (!ARESETn) begin
      exp_lvl0 = 0;
      exp_pk0 = 0;
    end else begin
      chk("u0_level", lvl0, exp_lvl0);
      chk("u0_pkt_count", pk0, exp_pk0);
      if (mv0 && mr0) begin
        got = {md0, ms0, mk0, ml0, mi0, mdst0, mu0};
        if (q0.size() == 0) chk("u0_unexpected_beat", 1, 0);
        else chk("u0_beat", got, q0.pop_front());
      end
      exp_lvl0 = exp_lvl0 + int'(sv0 && sr0) - int'(mv0 && mr0);
      exp_pk0 = exp_pk0 + int'(sv0 && sr0 && s_tlast)
                        - int'(mv0 && mr0 && ml0);
    end
  end

  always @(negedge ACLK) begin
    beat_t got;
    if (ARESETn && mv1 && mr1) begin
      got = {md1, ms1, mk1, ml1, mi1, mdst1, mu1};
      if (q1.size() == 0) chk("u1_unexpected_beat", 1, 0);
      else chk("u1_beat", got, q1.pop_front());
    end
  end

  task automatic send(input int u, input beat_t b);
    bit ok;
    ok = 1'b0;
    {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = b;
    if (u == 0) sv0 = 1'b1;
    else sv1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if ((u == 0) ? sr0 : sr1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    else if (u == 0) q0.push_back(b);
    else q1.push_back(b);
    @(posedge ACLK);
    #1;
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  task automatic drain(input int u);
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (((u == 0) ? lvl0 : lvl1) == '0) break;
    end
    chk("drain_level", (u == 0) ? lvl0 : lvl1, 0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    time t0;
    ARESETn = 1'b0;
    sv0 = 0; sv1 = 0; mr0 = 0; mr1 = 0;
    {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = '0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_s_tready", sr0, 0);
    chk("rst_m_tvalid", mv0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_pkt_count", pk0, 0);
    chk("rst_oversize", ov1, 0);
    @(negedge ACLK);
    #1;
    ARESETn = 1'b1;
    #1;
    chk("release_ready_low", sr0, 0);
    @(posedge ACLK);
    #1;
    chk("release_ready_high", sr0, 1);

    // Single-beat packets, one cycle latency
    mr0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(0, mk(32'h11 * i, 4'hF, 4'hF, 1'b1, 4'(i), 4'(i + 1), 4'(i + 2)));
      chk("t1_m_tvalid", mv0, 1);
      chk("t1_level", lvl0, 1);
    end
    drain(0);

    // Fill to DEPTH, then a single read
    mr0 = 1'b0;
    for (int i = 0; i < 16; i++)
      send(0, mk(32'h100 + i, 4'hF, 4'hF, 1'b0, 4'(i), 4'h0, 4'h0));
    chk("full_s_tready", sr0, 0);
    chk("full_level", lvl0, 16);
    mr0 = 1'b1;
    @(posedge ACLK);
    #1;
    mr0 = 1'b0;
    chk("after_read_s_tready", sr0, 1);
    chk("after_read_level", lvl0, 15);
    mr0 = 1'b1;
    drain(0);

    // 100-beat stream at full throughput
    t0 = $time;
    for (int i = 0; i < 100; i++) begin
      send(0, mk(32'h1000 + i, 4'hF, 4'hF, i[0], 4'(i), 4'(i + 3), 4'(i + 7)));
      chk("stream_level", lvl0, 1);
    end
    chk("stream_cycles", 64'(($time - t0) / 10), 100);
    drain(0);

    // Store-and-forward: 5-beat packet with gaps
    mr1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, mk(32'hA0 + i, 4'hF, 4'hF, i == 4, 4'h5, 4'h6, 4'(i)));
      if (i < 4) begin
        chk("saf_hold_m_tvalid", mv1, 0);
        repeat (2) @(posedge ACLK);
        #1;
      end
    end
    chk("saf_m_tvalid", mv1, 1);
    chk("saf_pkt_count", pk1, 1);
    chk("saf_level", lvl1, 5);
    repeat (4) @(posedge ACLK);
    #1;
    chk("saf_b2b_m_tvalid", mv1, 1);
    chk("saf_b2b_pkt_count", pk1, 1);
    @(posedge ACLK);
    #1;
    chk("saf_done_level", lvl1, 0);
    chk("saf_done_pkt_count", pk1, 0);

    // Oversize packet then reset mid-stream
    mr1 = 1'b0;
    for (int i = 0; i < 16; i++)
      send(1, mk(32'h500 + i, 4'hF, 4'hF, 1'b0, 4'h1, 4'h2, 4'h3));
    chk("ovf_s_tready", sr1, 0);
    chk("ovf_level", lvl1, 16);
    chk("ovf_m_tvalid", mv1, 0);
    @(posedge ACLK);
    #1;
    chk("ovf_flag", ov1, 1);
    @(posedge ACLK);
    #1;
    chk("ovf_flag_held", ov1, 1);
    chk("ovf_ready_held", sr1, 0);
    {s_tdata, s_tlast} = {32'h5FF, 1'b0};
    sv1 = 1'b1;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_s_tready", sr1, 0);
    chk("mid_rst_m_tvalid", mv1, 0);
    chk("mid_rst_level", lvl1, 0);
    chk("mid_rst_pkt_count", pk1, 0);
    chk("mid_rst_oversize", ov1, 0);
    sv1 = 1'b0;
    q1.delete();
    @(negedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("rerelease_s_tready", sr1, 1);

    // Null bytes under random m_tready
    mr0 = 1'b0;
    fork
      for (int i = 0; i < 12; i++)
        send(0, mk(32'hDEADBEEF, 4'h1, 4'h3, i[0], 4'(i), 4'h9, 4'hC));
      repeat (60) begin
        @(posedge ACLK);
        #1;
        mr0 = 1'($urandom_range(0, 1));
      end
    join
    mr0 = 1'b1;
    drain(0);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
